// File: rtl/synch_pkg.sv
// Shared horizontal video timing constants for the Pentagon 448-clock line.
// Used by synch and the vertical stage so both agree on line geometry.
package synch_pkg;

  localparam int unsigned HCOUNT_W = 9;
  typedef logic [HCOUNT_W-1:0] hcount_t;

  localparam int unsigned VID_HPERIOD    = 448;
  localparam int unsigned VID_HBLNK_BEG  = 0;
  localparam int unsigned VID_HSYNC_BEG  = 10;
  localparam int unsigned VID_HSYNC_END  = 43;
  localparam int unsigned VID_HBLNK_END  = 88;
  localparam int unsigned VID_HPIX_BEG   = 140;
  localparam int unsigned VID_HPIX_END   = 396;
  localparam int unsigned VID_HINT_BEG   = 2;
  localparam int unsigned VID_FETCH_LEAD = 16;

  function automatic hcount_t to_hcount(input int unsigned v);
    return hcount_t'(v);
  endfunction

endpackage

// File: rtl/synch_if.sv
// Horizontal timing bus: pixel enable in, blank/sync/pixel levels and strobes out.
// Fetch strobes exist only when SYNCH_FETCH_EN is defined.
interface synch_if;

  logic cend;
  logic hblank;
  logic hsync;
  logic hpix;
  logic hsync_start;
  logic line_start;
  logic hint_start;
`ifdef SYNCH_FETCH_EN
  logic fetch_start;
  logic fetch_end;
`endif

`ifdef SYNCH_FETCH_EN
  modport master (
    input  cend,
    output hblank, hsync, hpix, hsync_start, line_start, hint_start, fetch_start, fetch_end
  );

  modport slave (
    output cend,
    input  hblank, hsync, hpix, hsync_start, line_start, hint_start, fetch_start, fetch_end
  );
`else
  modport master (
    input  cend,
    output hblank, hsync, hpix, hsync_start, line_start, hint_start
  );

  modport slave (
    output cend,
    input  hblank, hsync, hpix, hsync_start, line_start, hint_start
  );
`endif

endinterface

// File: rtl/synch.sv
// Horizontal timing generator: counts cend strobes across a line, emits levels and strobes.
// Optional fetch strobes are built when SYNCH_FETCH_EN is defined.
module synch
  import synch_pkg::*;
#(
`ifdef SYNCH_FETCH_EN
  parameter int unsigned FETCH_LEAD = VID_FETCH_LEAD,
`endif
  parameter int unsigned HPERIOD   = VID_HPERIOD,
  parameter int unsigned HBLNK_BEG = VID_HBLNK_BEG,
  parameter int unsigned HSYNC_BEG = VID_HSYNC_BEG,
  parameter int unsigned HSYNC_END = VID_HSYNC_END,
  parameter int unsigned HBLNK_END = VID_HBLNK_END,
  parameter int unsigned HPIX_BEG  = VID_HPIX_BEG,
  parameter int unsigned HPIX_END  = VID_HPIX_END,
  parameter int unsigned HINT_BEG  = VID_HINT_BEG
) (
  input logic     clk,
  input logic     rst,
  synch_if.master bus
);

  localparam hcount_t HLast     = to_hcount(HPERIOD - 1);
  localparam hcount_t HBlnkBeg  = to_hcount(HBLNK_BEG);
  localparam hcount_t HSyncBeg  = to_hcount(HSYNC_BEG);
  localparam hcount_t HSyncEnd  = to_hcount(HSYNC_END);
  localparam hcount_t HBlnkEnd  = to_hcount(HBLNK_END);
  localparam hcount_t HPixBeg   = to_hcount(HPIX_BEG);
  localparam hcount_t HPixEnd   = to_hcount(HPIX_END);
  localparam hcount_t HIntBeg   = to_hcount(HINT_BEG);
`ifdef SYNCH_FETCH_EN
  localparam hcount_t HFetchBeg = to_hcount(HPIX_BEG - FETCH_LEAD);
  localparam hcount_t HFetchEnd = to_hcount(HPIX_END - FETCH_LEAD);
`endif

  hcount_t hcount_q, hcount_d;
  logic hblank_q, hblank_d;
  logic hsync_q, hsync_d;
  logic hpix_q, hpix_d;
  logic hsync_start_q, hsync_start_d;
  logic line_start_q, line_start_d;
  logic hint_start_q, hint_start_d;
`ifdef SYNCH_FETCH_EN
  logic fetch_start_q, fetch_start_d;
  logic fetch_end_q, fetch_end_d;
`endif

  always_comb begin
    hcount_d = hcount_q;
    hblank_d = hblank_q;
    hsync_d  = hsync_q;
    hpix_d   = hpix_q;

    // Strobes decode the pre-increment count, so they drop as soon as cend drops.
    hsync_start_d = bus.cend && (hcount_q == HSyncBeg);
    line_start_d  = bus.cend && (hcount_q == HBlnkEnd);
    hint_start_d  = bus.cend && (hcount_q == HIntBeg);
`ifdef SYNCH_FETCH_EN
    fetch_start_d = bus.cend && (hcount_q == HFetchBeg);
    fetch_end_d   = bus.cend && (hcount_q == HFetchEnd);
`endif

    if (bus.cend) begin
      hcount_d = (hcount_q == HLast) ? '0 : hcount_q + hcount_t'(1);

      if (hcount_q == HBlnkBeg) begin
        hblank_d = 1'b1;
      end else if (hcount_q == HBlnkEnd) begin
        hblank_d = 1'b0;
      end

      if (hcount_q == HSyncBeg) begin
        hsync_d = 1'b1;
      end else if (hcount_q == HSyncEnd) begin
        hsync_d = 1'b0;
      end

      if (hcount_q == HPixBeg) begin
        hpix_d = 1'b1;
      end else if (hcount_q == HPixEnd) begin
        hpix_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q      <= '0;
      hblank_q      <= 1'b0;
      hsync_q       <= 1'b0;
      hpix_q        <= 1'b0;
      hsync_start_q <= 1'b0;
      line_start_q  <= 1'b0;
      hint_start_q  <= 1'b0;
`ifdef SYNCH_FETCH_EN
      fetch_start_q <= 1'b0;
      fetch_end_q   <= 1'b0;
`endif
    end else begin
      hcount_q      <= hcount_d;
      hblank_q      <= hblank_d;
      hsync_q       <= hsync_d;
      hpix_q        <= hpix_d;
      hsync_start_q <= hsync_start_d;
      line_start_q  <= line_start_d;
      hint_start_q  <= hint_start_d;
`ifdef SYNCH_FETCH_EN
      fetch_start_q <= fetch_start_d;
      fetch_end_q   <= fetch_end_d;
`endif
    end
  end

  assign bus.hblank      = hblank_q;
  assign bus.hsync       = hsync_q;
  assign bus.hpix        = hpix_q;
  assign bus.hsync_start = hsync_start_q;
  assign bus.line_start  = line_start_q;
  assign bus.hint_start  = hint_start_q;
`ifdef SYNCH_FETCH_EN
  assign bus.fetch_start = fetch_start_q;
  assign bus.fetch_end   = fetch_end_q;
`endif

endmodule
